// File: rtl/mips_irq_timer.sv
// mips_irq_timer
//   Interval timer plus 5-source interrupt controller on the MIPS core's cop bus.
//   Sources 0..3 are the external lines (synchronized, rising-edge detected);
//   source 4 is the timer expiry. A 3-state FSM presents one request at a
//   time to the core, with a handler address of VBASE + ID*8.
//
// Register window (word offsets from BASE_ADDR):
//   0x00 CTRL   rw  {GIE, ARL, TEN}
//   0x04 RELOAD rw  write also loads COUNT
//   0x08 COUNT  ro
//   0x0C MASK   rw  [4:0]
//   0x10 PEND   r / write-1-to-clear [4:0]
//   0x14 VBASE  rw  [31:3], [2:0] read 0
//
// Ports:
//   clk, rst          core clock, async active-low reset
//   cop_addr_i        byte address of the access
//   cop_data_i        store data
//   cop_mem_ctl_i     memory control; SW_CODE marks a word store
//   cop_dout_o        combinational read data (0 on miss/unmapped)
//   ext_irq_i         asynchronous external interrupt lines
//   iack_i            interrupt acknowledge from the core
//   irq_o             interrupt request to the core
//   irq_addr_o        handler address, held while irq_o is low

// Per-line synchronizer: two flops against metastability, a third flop
// remembers the previous synchronized level for edge detection.
module mips_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

module mips_irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [3:0]  SW_CODE   = 4'h6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cop_addr_i,
  input  logic [31:0] cop_data_i,
  input  logic [3:0]  cop_mem_ctl_i,
  output logic [31:0] cop_dout_o,
  input  logic [3:0]  ext_irq_i,
  input  logic        iack_i,
  output logic        irq_o,
  output logic [31:0] irq_addr_o
);
  localparam int NUM_LINES = 4;
  localparam int NUM_SRC   = NUM_LINES + 1;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_RELOAD = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_MASK   = 3'd3;
  localparam logic [2:0] OFF_PEND   = 3'd4;
  localparam logic [2:0] OFF_VBASE  = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  typedef struct packed {
    logic       hit;
    logic       we;
    logic [2:0] off;
  } bus_req_t;

  // ---------------------------------------------------------------- bus decode
  bus_req_t bus;

  always_comb begin
    bus     = '0;
    bus.hit = (cop_addr_i[31:5] == BASE_ADDR[31:5]);
    bus.off = cop_addr_i[4:2];
    bus.we  = bus.hit && (cop_mem_ctl_i == SW_CODE);
  end

  // Byte lanes are not decoded; the block only takes word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cop_addr_i[1:0];

  logic wr_ctrl, wr_reload, wr_mask, wr_pend, wr_vbase;
  assign wr_ctrl   = bus.we && (bus.off == OFF_CTRL);
  assign wr_reload = bus.we && (bus.off == OFF_RELOAD);
  assign wr_mask   = bus.we && (bus.off == OFF_MASK);
  assign wr_pend   = bus.we && (bus.off == OFF_PEND);
  assign wr_vbase  = bus.we && (bus.off == OFF_VBASE);

  // ------------------------------------------------------------ state storage
  logic               ten, arl, gie;
  logic [31:0]        reload, count;
  logic [NUM_SRC-1:0] mask, pend;
  logic [31:3]        vbase;
  state_t             state;
  logic [2:0]         id;

  // ------------------------------------------------------- external sources
  logic [NUM_LINES-1:0] ext_rise;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_sync
    mips_irq_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .line (ext_irq_i[g]),
      .rise (ext_rise[g])
    );
  end

  // The synchronizers come out of reset at 0, so a line already high would
  // look like a fresh edge once it reaches the edge flop. Edge detection is
  // held off until the chain has filled with real samples (3 edges).
  logic [1:0] arm_cnt;
  logic       armed;
  assign armed = &arm_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        arm_cnt <= 2'd0;
    else if (!armed) arm_cnt <= arm_cnt + 2'd1;
  end

  // -------------------------------------------------------------------- timer
  // A RELOAD write wins over counting, so no expiry is taken that cycle.
  logic timer_fire;
  assign timer_fire = ten && (count == 32'd1) && !wr_reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload <= '0;
      count  <= '0;
    end else if (wr_reload) begin
      reload <= cop_data_i;
      count  <= cop_data_i;
    end else if (ten && (count != 32'd0)) begin
      if (count == 32'd1) count <= arl ? reload : 32'd0;
      else                count <= count - 32'd1;
    end
  end

  // --------------------------------------------------------------- interrupt
  logic               ack;
  logic [NUM_SRC-1:0] pend_qual, pend_set, ack_clr, w1c_clr;
  logic [2:0]         nxt_id;

  assign ack       = (state == REQ) && iack_i;
  assign pend_qual = pend & mask;
  assign pend_set  = {timer_fire, ext_rise & {NUM_LINES{armed}}};
  assign ack_clr   = ack ? (NUM_SRC'(1) << id) : '0;
  assign w1c_clr   = wr_pend ? cop_data_i[NUM_SRC-1:0] : '0;

  // Lowest set index has priority.
  always_comb begin
    nxt_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend_qual[i]) nxt_id = 3'(i);
  end

  // New events beat both clear paths for the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~(w1c_clr | ack_clr)) | pend_set;
  end

  // A software CTRL write wins over hardware clearing of TEN/GIE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ten <= 1'b0;
      arl <= 1'b0;
      gie <= 1'b0;
    end else if (wr_ctrl) begin
      {gie, arl, ten} <= cop_data_i[2:0];
    end else begin
      if (timer_fire && !arl) ten <= 1'b0;
      if (ack)                gie <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= '0;
      vbase <= 29'(32'h0000_0050 >> 3);
    end else begin
      if (wr_mask)  mask  <= cop_data_i[NUM_SRC-1:0];
      if (wr_vbase) vbase <= cop_data_i[31:3];
    end
  end

  // Request FSM. irq_o/irq_addr_o are registered and only change on entry
  // to REQ (both) and on acknowledge (irq_o), so REQ is immune to MASK/GIE
  // /PEND changes and the address persists while irq_o is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      id         <= '0;
      irq_o      <= 1'b0;
      irq_addr_o <= '0;
    end else begin
      unique case (state)
        IDLE: if (gie && (pend_qual != '0)) begin
          id         <= nxt_id;
          irq_o      <= 1'b1;
          irq_addr_o <= {vbase + 29'(nxt_id), 3'b000};
          state      <= REQ;
        end
        REQ: if (iack_i) begin
          irq_o <= 1'b0;
          state <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- readback
  always_comb begin
    cop_dout_o = '0;
    if (bus.hit) begin
      case (bus.off)
        OFF_CTRL:   cop_dout_o = {29'd0, gie, arl, ten};
        OFF_RELOAD: cop_dout_o = reload;
        OFF_COUNT:  cop_dout_o = count;
        OFF_MASK:   cop_dout_o = {27'd0, mask};
        OFF_PEND:   cop_dout_o = {27'd0, pend};
        OFF_VBASE:  cop_dout_o = {vbase, 3'b000};
        default:    cop_dout_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_irq_timer.sv
// Bench for mips_irq_timer: directed scenarios with literal expectations,
// then randomized bus/line/ack traffic, all shadowed by a behavioural model
// and checked every cycle on the falling clock edge.
module tb_mips_irq_timer;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [3:0]  SW   = 4'h6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cop_addr_i = BASE;
  logic [31:0] cop_data_i = '0;
  logic [3:0]  cop_mem_ctl_i = '0;
  logic [31:0] cop_dout_o;
  logic [3:0]  ext_irq_i = '0;
  logic        iack_i = 1'b0;
  logic        irq_o;
  logic [31:0] irq_addr_o;

  mips_irq_timer #(.BASE_ADDR(BASE), .SW_CODE(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cop_addr_i   (cop_addr_i),
    .cop_data_i   (cop_data_i),
    .cop_mem_ctl_i(cop_mem_ctl_i),
    .cop_dout_o   (cop_dout_o),
    .ext_irq_i    (ext_irq_i),
    .iack_i       (iack_i),
    .irq_o        (irq_o),
    .irq_addr_o   (irq_addr_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- behavioural model
  // Registers as plain variables; external lines as a sample history
  // (an edge is seen 2 samples late, and not before 3 clocks after reset);
  // the requester as "is a request outstanding / in cool-down".
  bit          m_ten = 0, m_arl = 0, m_gie = 0;
  logic [31:0] m_reload = '0, m_count = '0;
  logic [4:0]  m_mask = '0, m_pend = '0;
  logic [31:3] m_vbase = 29'd10;
  bit          m_outstanding = 0, m_cool = 0;
  int          m_id = 0;
  bit          m_irq = 0;
  logic [31:0] m_irq_addr = '0;
  logic [3:0]  m_hist[$];
  int          m_n = 0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0:    return {29'd0, m_gie, m_arl, m_ten};
      3'd1:    return m_reload;
      3'd2:    return m_count;
      3'd3:    return {27'd0, m_mask};
      3'd4:    return {27'd0, m_pend};
      3'd5:    return {m_vbase, 3'b000};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit         we;
    int         off;
    logic [4:0] set_b, clr_b, q;
    bit         ten_n, gie_n;
    if (!rst) begin
      m_ten = 0; m_arl = 0; m_gie = 0;
      m_reload = '0; m_count = '0; m_mask = '0; m_pend = '0;
      m_vbase = 29'd10;
      m_outstanding = 0; m_cool = 0; m_id = 0;
      m_irq = 0; m_irq_addr = '0;
      m_hist.delete(); m_n = 0;
    end else begin
      we    = (cop_addr_i[31:5] == BASE[31:5]) && (cop_mem_ctl_i == SW);
      off   = int'(cop_addr_i[4:2]);
      set_b = '0;
      clr_b = '0;
      ten_n = m_ten;
      gie_n = m_gie;
      // external edges
      if (m_n >= 3) set_b[3:0] = m_hist[1] & ~m_hist[2];
      m_hist.push_front(ext_irq_i);
      if (m_hist.size() > 3) void'(m_hist.pop_back());
      m_n++;
      // requester
      if (m_cool) m_cool = 0;
      else if (m_outstanding) begin
        if (iack_i) begin
          clr_b[m_id] = 1'b1;
          gie_n = 0;
          m_irq = 0;
          m_outstanding = 0;
          m_cool = 1;
        end
      end else begin
        q = m_pend & m_mask;
        if (m_gie && q != 0) begin
          for (int i = 0; i < 5; i++) if (q[i]) begin m_id = i; break; end
          m_irq = 1;
          m_irq_addr = 32'(m_vbase) * 8 + 32'(m_id) * 8;
          m_outstanding = 1;
        end
      end
      // timer
      if (we && off == 1) begin
        m_reload = cop_data_i;
        m_count  = cop_data_i;
      end else if (m_ten && m_count != 0) begin
        if (m_count == 1) begin
          set_b[4] = 1'b1;
          if (m_arl) m_count = m_reload;
          else begin m_count = 0; ten_n = 0; end
        end else m_count = m_count - 1;
      end
      // software writes
      if (we && off == 0) begin
        m_ten = cop_data_i[0]; m_arl = cop_data_i[1]; m_gie = cop_data_i[2];
      end else begin
        m_ten = ten_n; m_gie = gie_n;
      end
      if (we && off == 3) m_mask = cop_data_i[4:0];
      if (we && off == 4) clr_b = clr_b | cop_data_i[4:0];
      if (we && off == 5) m_vbase = cop_data_i[31:3];
      m_pend = (m_pend & ~clr_b) | set_b;
    end
  end

  // ---------------------------------------------------------- cycle compare
  always @(negedge clk) begin
    chk("dout", cop_dout_o, m_read(cop_addr_i));
    chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
    chk("irq_addr", irq_addr_o, m_irq_addr);
  end

  // ----------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    cop_addr_i    = BASE + 32'(off);
    cop_data_i    = d;
    cop_mem_ctl_i = SW;
    tick();
    cop_mem_ctl_i = 4'h0;
  endtask

  task automatic rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
    cop_addr_i    = BASE + 32'(off);
    cop_mem_ctl_i = 4'h0;
    @(negedge clk);
    chk(nm, cop_dout_o, exp);
    tick();
  endtask

  // Returns on a falling edge with irq_o high, or flags a timeout.
  task automatic wait_irq(input string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (irq_o) break;
      @(posedge clk); #1;
    end
    chk({nm, "_irq_seen"}, {31'd0, irq_o}, 32'd1);
  endtask

  task automatic ack();
    iack_i = 1'b1;
    tick();
    iack_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // reset values and decode
    rd("rst_ctrl", 8'h00, 32'h0);
    rd("rst_reload", 8'h04, 32'h0);
    rd("rst_count", 8'h08, 32'h0);
    rd("rst_mask", 8'h0C, 32'h0);
    rd("rst_pend", 8'h10, 32'h0);
    rd("rst_vbase", 8'h14, 32'h50);
    wr(8'h0C, 32'hFFFF_FFFF);
    rd("mask_bits", 8'h0C, 32'h1F);
    rd("unmapped", 8'h18, 32'h0);
    rd("miss", 8'h2C, 32'h0);
    wr(8'h0C, 32'h0);

    // timer one-shot
    wr(8'h04, 32'd5);
    wr(8'h00, 32'h1);
    rd("os_cnt5", 8'h08, 32'd5);
    rd("os_cnt4", 8'h08, 32'd4);
    rd("os_cnt3", 8'h08, 32'd3);
    rd("os_cnt2", 8'h08, 32'd2);
    rd("os_cnt1", 8'h08, 32'd1);
    rd("os_cnt0", 8'h08, 32'd0);
    rd("os_pend", 8'h10, 32'h10);
    rd("os_ten", 8'h00, 32'h0);
    wr(8'h10, 32'h1F);

    // timer interrupt with auto-reload
    wr(8'h0C, 32'h10);
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h7);
    wait_irq("tmr");
    chk("tmr_addr", irq_addr_o, 32'h70);
    ack();
    rd("tmr_pend_clr", 8'h10, 32'h0);
    rd("tmr_gie_off", 8'h00, 32'h3);
    rd("tmr_reload_again", 8'h10, 32'h10);
    wr(8'h00, 32'h0);
    wr(8'h10, 32'h1F);
    wr(8'h0C, 32'h0);

    // priority among simultaneous external edges
    wr(8'h0C, 32'h1F);
    wr(8'h00, 32'h4);
    ext_irq_i = 4'b1010;
    wait_irq("pri1");
    chk("pri1_addr", irq_addr_o, 32'h58);
    ack();
    rd("pri1_pend", 8'h10, 32'h08);
    ext_irq_i = 4'b0000;
    wr(8'h00, 32'h4);
    wait_irq("pri3");
    chk("pri3_addr", irq_addr_o, 32'h68);
    ack();
    rd("pri3_pend", 8'h10, 32'h0);

    // request holds through MASK/GIE changes
    wr(8'h00, 32'h4);
    ext_irq_i = 4'b0100;
    wait_irq("hold");
    tick();
    wr(8'h0C, 32'h0);
    wr(8'h00, 32'h0);
    @(negedge clk);
    chk("hold_irq", {31'd0, irq_o}, 32'd1);
    chk("hold_addr", irq_addr_o, 32'h60);
    ack();
    @(negedge clk);
    chk("hold_drop", {31'd0, irq_o}, 32'd0);
    chk("hold_addr_kept", irq_addr_o, 32'h60);
    tick();
    ext_irq_i = 4'b0000;

    // set beats W1C on the same edge
    ext_irq_i = 4'b0001;
    repeat (4) tick();
    rd("col_pend_a", 8'h10, 32'h01);
    ext_irq_i = 4'b0000;
    repeat (3) tick();
    ext_irq_i = 4'b0001;
    tick();
    tick();
    wr(8'h10, 32'h01);
    rd("col_pend_b", 8'h10, 32'h01);
    ext_irq_i = 4'b0000;
    wr(8'h10, 32'h1F);

    // RELOAD write during countdown
    wr(8'h04, 32'd100);
    wr(8'h00, 32'h1);
    repeat (3) tick();
    wr(8'h04, 32'h40);
    rd("col_count", 8'h08, 32'h40);
    wr(8'h00, 32'h0);

    // RELOAD=0 never fires
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h3);
    repeat (5) tick();
    rd("zero_pend", 8'h10, 32'h0);
    rd("zero_count", 8'h08, 32'h0);
    wr(8'h00, 32'h0);

    // reset during a request, lines high through release
    wr(8'h0C, 32'h1F);
    wr(8'h00, 32'h4);
    ext_irq_i = 4'b0010;
    wait_irq("rst");
    chk("rst_req_addr", irq_addr_o, 32'h58);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_async_addr", irq_addr_o, 32'h0);
    ext_irq_i = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    rd("rst2_ctrl", 8'h00, 32'h0);
    rd("rst2_reload", 8'h04, 32'h0);
    rd("rst2_count", 8'h08, 32'h0);
    rd("rst2_mask", 8'h0C, 32'h0);
    rd("rst2_vbase", 8'h14, 32'h50);
    repeat (4) tick();
    rd("rst2_pend", 8'h10, 32'h0);

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      int off;
      logic [3:0] bitsel;
      off = int'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) cop_addr_i = $urandom();
      else cop_addr_i = BASE + 32'(off * 4);
      cop_mem_ctl_i = ($urandom_range(0, 3) == 0) ? SW : 4'($urandom_range(0, 15));
      case (off)
        0:       cop_data_i = 32'($urandom_range(0, 7));
        1:       cop_data_i = 32'($urandom_range(0, 9));
        default: cop_data_i = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) begin
        bitsel = 4'b0001 << $urandom_range(0, 3);
        ext_irq_i = ext_irq_i ^ bitsel;
      end
      iack_i = ($urandom_range(0, 3) == 0);
      if (c % 1000 == 999) begin
        #3 rst = 1'b0;
        #2 rst = 1'b1;
      end
      tick();
    end
    cop_mem_ctl_i = 4'h0;
    iack_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_irq_timer.md
MIPS_IRQ_TIMER -- requirements
Module: mips_irq_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7F00, the base of the block's register window on the core's cop bus.
REQ-002 SHALL have parameter SW_CODE, default 4'h6, the cop_mem_ctl code that qualifies a word store.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 SHALL have the following ports, one per line:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cop_addr_i  in  32  byte address from the core's cop_addr_o.
- cop_data_i  in  32  store data from the core's cop_data_o.
- cop_mem_ctl_i  in  4  memory control from the core's cop_mem_ctl_o.
- cop_dout_o  out  32  read data to the core's cop_dout.
- ext_irq_i  in  4  asynchronous external interrupt lines.
- iack_i  in  1  interrupt acknowledge from the core's iack_o.
- irq_o  out  1  interrupt request to the core's irq_i.
- irq_addr_o  out  32  handler address to the core's irq_addr.

Function
REQ-005 SHALL decode a hit when cop_addr_i[31:5] == BASE_ADDR[31:5], with register offset cop_addr_i[4:2].
REQ-006 SHALL perform a write on a rising edge when there is a hit and cop_mem_ctl_i == SW_CODE; any other ctl value SHALL not write.
REQ-007 SHALL drive cop_dout_o combinationally with the addressed register on a hit, unused bits 0, and 32'h0 on a miss or an unmapped offset.
REQ-008 SHALL implement these registers (offset: name, access):
- 0x00: CTRL, rw; bit0 TEN (timer enable), bit1 ARL (auto-reload), bit2 GIE (global interrupt enable).
- 0x04: RELOAD, rw, 32 bits; a write also loads COUNT with the written value.
- 0x08: COUNT, read-only.
- 0x0C: MASK, rw, bits[4:0].
- 0x10: PEND, read; write-1-to-clear on bits[4:0].
- 0x14: VBASE, rw, bits[31:3]; bits[2:0] read as 0.
REQ-009 SHALL pass each ext_irq_i bit through a 2-flop synchronizer plus an edge register, and SHALL set PEND[n] on a 0->1 transition of synchronized line n (n = 0..3).
REQ-010 SHALL decrement COUNT by 1 each cycle while TEN=1 and COUNT != 0.
REQ-011 SHALL, in the cycle where COUNT==1 and TEN=1:
- set PEND[4];
- load COUNT with RELOAD if ARL=1;
- otherwise set COUNT to 0 and clear TEN.
REQ-012 SHALL raise no timer event while COUNT==0, including when RELOAD==0.
REQ-013 SHALL give precedence to a bus write to RELOAD/COUNT over the decrement in the same cycle.
REQ-014 SHALL give precedence to a PEND set (edge or timer) over a W1C clear or an acknowledge clear of the same bit in the same cycle.
REQ-015 SHALL implement a 3-state FSM with states IDLE, REQ and HOLD.
REQ-016 In IDLE, when GIE=1 and (PEND & MASK) != 0, the FSM SHALL:
- latch ID = lowest set index of PEND & MASK;
- on the next edge assert irq_o=1 and drive irq_addr_o = VBASE + ID*8;
- enter REQ.
REQ-017 In REQ, the FSM SHALL hold irq_o and irq_addr_o stable until iack_i=1, even if MASK, GIE or PEND change.
REQ-018 When iack_i=1 in REQ, on that edge the FSM SHALL clear PEND[ID], clear GIE, deassert irq_o and enter HOLD.
REQ-019 HOLD SHALL last exactly one cycle and return to IDLE; software re-enables GIE.
REQ-020 The FSM SHALL ignore iack_i outside REQ.
REQ-021 irq_addr_o SHALL hold its last value when irq_o=0.
REQ-022 Request latency SHALL be 1 clk from qualifying PEND&MASK in IDLE to irq_o=1; synchronizer latency for ext_irq_i is 3 clk to PEND.

Reset
REQ-023 On rst=0 the block SHALL asynchronously clear:
- CTRL, RELOAD, COUNT, MASK and PEND to 0;
- VBASE to 32'h0000_0050;
- the synchronizers to 0;
- the FSM to IDLE, with irq_o=0 and irq_addr_o=32'h0.
REQ-024 Reset asserted mid-request (in REQ) SHALL drop irq_o immediately without requiring iack_i.
REQ-025 After reset release, lines already high on ext_irq_i SHALL not generate an edge event.

Verification
REQ-026 Bench SHALL cover:
- Timer one-shot: RELOAD=5, CTRL=0x1 -> COUNT reads 5,4,3,2,1,0; PEND=0x10 after 5 clk; TEN reads 0.
- Interrupt: MASK=0x10, CTRL=0x7, RELOAD=3 -> irq_o=1 with irq_addr_o=0x70; pulse iack_i -> irq_o=0, PEND[4]=0, GIE=0; auto-reload continues.
- Priority: ext_irq_i=4'b1010 rising together, MASK=0x1F, GIE=1 -> ID=1, irq_addr_o=0x58; after ack and GIE re-enabled -> ID=3, irq_addr_o=0x68.
- Hold in REQ: assert irq_o, then write MASK=0 and GIE=0 -> irq_o and irq_addr_o unchanged until iack_i.
- Collisions: W1C PEND[0] in the same cycle as a new edge on ext_irq_i[0] -> PEND[0]=1; RELOAD write during a decrement -> COUNT=written value.
- Reset: rst=0 while irq_o=1 -> irq_o=0 asynchronously; all registers read reset values; ext_irq_i held high through release -> PEND stays 0.
